// File: rtl/gptp_sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gptp_sd_pkg : shared types and constants for the gPTP send-side block |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gptp_sd_pkg;

   localparam int DEF_DATA_W = 352;
   localparam int DEF_TS_W   = 80;

   localparam int NS_LSB    = 0;
   localparam int SEC_LSB   = 32;
   localparam int EPOCH_LSB = 64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      OFFER   = 3'd1,
      HOLD    = 3'd2,
      WAIT_TS = 3'd3,
      REPORT  = 3'd4
   } state_t;

   // A write-back strobe is only meaningful while an offer is outstanding.
   function automatic logic in_capture(input state_t s);
      return (s == HOLD) || (s == WAIT_TS);
   endfunction

   function automatic logic [DEF_TS_W-1:0] ts_pack(input logic [15:0] epoch,
                                                   input logic [31:0] sec,
                                                   input logic [31:0] ns);
      logic [DEF_TS_W-1:0] t;
      t = '0;
      t[EPOCH_LSB +: 16] = epoch;
      t[SEC_LSB   +: 32] = sec;
      t[NS_LSB    +: 32] = ns;
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gptp_sd_stat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gptp_sd_stat_cnt : 16-bit saturating event counter with enable        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gptp_sd_stat_cnt (
   input  logic        clk_sd,
   input  logic        reset,
   input  logic        en,
   output logic [15:0] count
);

   always_ff @(posedge clk_sd) begin
      if (!reset)
         count <= '0;
      else if (en && (count != 16'hFFFF))
         count <= count + 16'd1;
   end

endmodule
`default_nettype wire

// File: rtl/gptp_sd_sender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gptp_sd_sender : offers a gPTP event frame to the timestamp bridge   |
// | and reports the egress timestamp. Optional: GPTP_SD_SENDER_STATS_EN  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gptp_sd_sender
   import gptp_sd_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TS_W        = DEF_TS_W,
   parameter int SEQ_W       = 16,
   parameter int HOLD_CYC    = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk_sd,
   input  logic              reset,
   input  logic              msg_valid,
   output logic              msg_ready,
   input  logic [DATA_W-1:0] msg_data,
   output logic              gptp_ts_vaild,
   input  logic              gptp_ts_ready,
   output logic [DATA_W-1:0] gptp_ts_data,
   input  logic              gptp_ts_rv_vaild,
   input  logic [TS_W-1:0]   gptp_ts_rv_data,
   output logic              egr_ts_valid,
   output logic [TS_W-1:0]   egr_ts_data,
   output logic [SEQ_W-1:0]  egr_seq,
   output logic              egr_timeout,
   output logic              busy
`ifdef GPTP_SD_SENDER_STATS_EN
   ,
   output logic [15:0]       stat_sent,
   output logic [15:0]       stat_timeout,
   output logic [15:0]       stat_stray
`endif
);

   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);

   state_t           state;
   logic [HW-1:0]    hold_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic             ts_got;
   logic [TS_W-1:0]  ts_cap;
   logic [SEQ_W-1:0] seq;

   assign msg_ready = (state == IDLE) & reset;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk_sd) begin
      if (!reset) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         tmo_cnt       <= '0;
         ts_got        <= 1'b0;
         ts_cap        <= '0;
         seq           <= '0;
         gptp_ts_vaild <= 1'b0;
         gptp_ts_data  <= '0;
         egr_ts_valid  <= 1'b0;
         egr_ts_data   <= '0;
         egr_seq       <= '0;
         egr_timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (msg_valid) begin
                  gptp_ts_data <= msg_data;
                  state        <= OFFER;
               end
            end
            OFFER: begin
               if (gptp_ts_ready) begin
                  gptp_ts_vaild <= 1'b1;
                  hold_cnt      <= '0;
                  tmo_cnt       <= '0;
                  ts_got        <= 1'b0;
                  state         <= HOLD;
               end
            end
            HOLD: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (gptp_ts_rv_vaild && !ts_got) begin
                  ts_cap <= gptp_ts_rv_data;
                  ts_got <= 1'b1;
               end
               if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                  gptp_ts_vaild <= 1'b0;
                  state         <= WAIT_TS;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            WAIT_TS: begin
               // A write-back arriving on the last timeout cycle still wins.
               if (ts_got || gptp_ts_rv_vaild) begin
                  egr_ts_valid <= 1'b1;
                  egr_timeout  <= 1'b0;
                  egr_ts_data  <= ts_got ? ts_cap : gptp_ts_rv_data;
                  egr_seq      <= seq;
                  state        <= REPORT;
               end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  egr_ts_valid <= 1'b1;
                  egr_timeout  <= 1'b1;
                  egr_ts_data  <= '0;
                  egr_seq      <= seq;
                  state        <= REPORT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            REPORT: begin
               egr_ts_valid <= 1'b0;
               egr_timeout  <= 1'b0;
               seq          <= seq + 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GPTP_SD_SENDER_STATS_EN
   logic rv_prev;

   always_ff @(posedge clk_sd) begin
      if (!reset)
         rv_prev <= 1'b0;
      else
         rv_prev <= gptp_ts_rv_vaild;
   end

   gptp_sd_stat_cnt u_stat_sent (
      .clk_sd (clk_sd),
      .reset  (reset),
      .en     (state == REPORT),
      .count  (stat_sent)
   );

   gptp_sd_stat_cnt u_stat_timeout (
      .clk_sd (clk_sd),
      .reset  (reset),
      .en     ((state == REPORT) && egr_timeout),
      .count  (stat_timeout)
   );

   gptp_sd_stat_cnt u_stat_stray (
      .clk_sd (clk_sd),
      .reset  (reset),
      .en     (gptp_ts_rv_vaild && !rv_prev && !in_capture(state)),
      .count  (stat_stray)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_gptp_sd_sender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gptp_sd_sender : directed self-checking bench for gptp_sd_sender  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gptp_sd_sender;
   import gptp_sd_pkg::*;

   localparam int DW = 352;
   localparam int TSW = 80;
   localparam int SW = 4;

   logic           clk_sd = 1'b0;
   logic           reset = 1'b0;
   logic           msg_valid = 1'b0;
   logic           msg_ready;
   logic [DW-1:0]  msg_data = '0;
   logic           gptp_ts_vaild;
   logic           gptp_ts_ready = 1'b0;
   logic [DW-1:0]  gptp_ts_data;
   logic           gptp_ts_rv_vaild = 1'b0;
   logic [TSW-1:0] gptp_ts_rv_data = '0;
   logic           egr_ts_valid;
   logic [TSW-1:0] egr_ts_data;
   logic [SW-1:0]  egr_seq;
   logic           egr_timeout;
   logic           busy;
`ifdef GPTP_SD_SENDER_STATS_EN
   logic [15:0]    stat_sent;
   logic [15:0]    stat_timeout;
   logic [15:0]    stat_stray;
`endif

   int errors = 0;
   int checks = 0;

   logic [DW-1:0]  pat_a;
   logic [DW-1:0]  pat_b;
   logic [TSW-1:0] wb_a;
   logic [TSW-1:0] wb_b;
   logic [TSW-1:0] wb_c;

   gptp_sd_sender #(.SEQ_W(SW)) dut (
      .clk_sd           (clk_sd),
      .reset            (reset),
      .msg_valid        (msg_valid),
      .msg_ready        (msg_ready),
      .msg_data         (msg_data),
      .gptp_ts_vaild    (gptp_ts_vaild),
      .gptp_ts_ready    (gptp_ts_ready),
      .gptp_ts_data     (gptp_ts_data),
      .gptp_ts_rv_vaild (gptp_ts_rv_vaild),
      .gptp_ts_rv_data  (gptp_ts_rv_data),
      .egr_ts_valid     (egr_ts_valid),
      .egr_ts_data      (egr_ts_data),
      .egr_seq          (egr_seq),
      .egr_timeout      (egr_timeout),
      .busy             (busy)
`ifdef GPTP_SD_SENDER_STATS_EN
      ,
      .stat_sent        (stat_sent),
      .stat_timeout     (stat_timeout),
      .stat_stray       (stat_stray)
`endif
   );

   always #5 clk_sd = ~clk_sd;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   // Stimulus only: one full message, optional write-back in the first WAIT_TS cycle.
   task automatic run_msg(input bit give_wb, input logic [TSW-1:0] wb,
                          output logic [SW-1:0] s, output bit tm,
                          output logic [TSW-1:0] d, output bit ok);
      int n;
      bit pv;
      ok = 0; s = '0; tm = 0; d = '0; pv = 0;
      gptp_ts_ready = 1'b1;
      msg_data  = pat_b;
      msg_valid = 1'b1;
      n = 0;
      while (msg_ready !== 1'b1 && n < 50) begin @(negedge clk_sd); n++; end
      @(negedge clk_sd);
      msg_valid = 1'b0;
      for (int t = 0; t < 1200; t++) begin
         @(negedge clk_sd);
         gptp_ts_rv_vaild = 1'b0;
         if (egr_ts_valid === 1'b1) begin
            s = egr_seq; tm = egr_timeout; d = egr_ts_data; ok = 1;
            break;
         end
         if (give_wb && pv && gptp_ts_vaild === 1'b0) begin
            gptp_ts_rv_vaild = 1'b1;
            gptp_ts_rv_data  = wb;
         end
         pv = (gptp_ts_vaild === 1'b1);
      end
      gptp_ts_rv_vaild = 1'b0;
   endtask

   // Stimulus only: offer, then index cycles from the first gptp_ts_vaild cycle.
   task automatic timed_offer(input int wb_at, input logic [TSW-1:0] wb,
                              output int rep_at, output logic [SW-1:0] s,
                              output logic tm, output logic [TSW-1:0] d);
      int n;
      gptp_ts_ready = 1'b1;
      msg_data  = pat_b;
      msg_valid = 1'b1;
      n = 0;
      while (msg_ready !== 1'b1 && n < 50) begin @(negedge clk_sd); n++; end
      @(negedge clk_sd);
      msg_valid = 1'b0;
      n = 0;
      while (gptp_ts_vaild !== 1'b1 && n < 50) begin @(negedge clk_sd); n++; end
      rep_at = -1; s = '0; tm = 1'b0; d = '0;
      for (int t = 0; t < 1100; t++) begin
         if (egr_ts_valid === 1'b1) begin
            rep_at = t; s = egr_seq; tm = egr_timeout; d = egr_ts_data;
            break;
         end
         gptp_ts_rv_vaild = (t == wb_at);
         gptp_ts_rv_data  = wb;
         @(negedge clk_sd);
      end
      gptp_ts_rv_vaild = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk_sd);
      checks++;
      if (msg_ready !== 1'b0) begin errors++; $display("FAIL reset_msg_ready: got %b want 0", msg_ready); end
      checks++;
      if ({gptp_ts_vaild, egr_ts_valid, egr_timeout, busy} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b want 0000", {gptp_ts_vaild, egr_ts_valid, egr_timeout, busy});
      end
      checks++;
      if (gptp_ts_data !== '0 || egr_ts_data !== '0 || egr_seq !== '0) begin
         errors++; $display("FAIL reset_data: egr_seq=%0d egr_ts_data=%h want 0", egr_seq, egr_ts_data);
      end
      reset = 1'b1;
      @(negedge clk_sd);
      checks++;
      if (msg_ready !== 1'b1) begin errors++; $display("FAIL idle_msg_ready: got %b want 1", msg_ready); end
   endtask

   task automatic test_normal();
      int vcnt, reps, last_v, rep_at;
      logic [SW-1:0] s;
      logic tm;
      logic [TSW-1:0] d;
      vcnt = 0; reps = 0; last_v = -1; rep_at = -1; s = '0; tm = 1'b0; d = '0;
      gptp_ts_ready = 1'b1;
      msg_data  = pat_a;
      msg_valid = 1'b1;
      @(negedge clk_sd);
      msg_valid = 1'b0;
      checks++;
      if (gptp_ts_data !== pat_a) begin errors++; $display("FAIL normal_load: got %h want %h", gptp_ts_data[31:0], pat_a[31:0]); end
      for (int t = 0; t < 30; t++) begin
         @(negedge clk_sd);
         if (gptp_ts_vaild === 1'b1) begin vcnt++; last_v = t; end
         if (egr_ts_valid === 1'b1) begin reps++; rep_at = t; s = egr_seq; tm = egr_timeout; d = egr_ts_data; end
         gptp_ts_rv_vaild = (gptp_ts_vaild === 1'b1) && (vcnt == 3 || vcnt == 4);
         gptp_ts_rv_data  = wb_a;
      end
      gptp_ts_rv_vaild = 1'b0;
      checks++;
      if (vcnt != 8) begin errors++; $display("FAIL normal_hold_len: got %0d want 8", vcnt); end
      checks++;
      if (reps != 1) begin errors++; $display("FAIL normal_report_count: got %0d want 1", reps); end
      checks++;
      if (rep_at != last_v + 2) begin errors++; $display("FAIL normal_latency: got %0d want %0d", rep_at, last_v + 2); end
      checks++;
      if (s !== 4'd0 || tm !== 1'b0) begin errors++; $display("FAIL normal_seq_tmo: got seq=%0d tmo=%b want 0/0", s, tm); end
      checks++;
      if (d !== wb_a) begin errors++; $display("FAIL normal_ts: got %h want %h", d, wb_a); end
   endtask

   task automatic test_ready_late();
      bit bad_v, bad_d, bad_r, bad_b;
      int n;
      bad_v = 0; bad_d = 0; bad_r = 0; bad_b = 0;
      gptp_ts_ready = 1'b0;
      msg_data  = pat_b;
      msg_valid = 1'b1;
      @(negedge clk_sd);
      msg_valid = 1'b0;
      msg_data  = pat_a;
      for (int t = 0; t < 20; t++) begin
         if (gptp_ts_vaild !== 1'b0) bad_v = 1;
         if (gptp_ts_data !== pat_b) bad_d = 1;
         if (msg_ready !== 1'b0) bad_r = 1;
         if (busy !== 1'b1) bad_b = 1;
         @(negedge clk_sd);
      end
      checks++;
      if (bad_v) begin errors++; $display("FAIL late_vaild_early: got 1 want 0 while ready=0"); end
      checks++;
      if (bad_d) begin errors++; $display("FAIL late_data_stable: got changed want %h", pat_b[31:0]); end
      checks++;
      if (bad_r || bad_b) begin errors++; $display("FAIL late_ready_busy: got msg_ready/busy wrong want 0/1"); end
      gptp_ts_ready = 1'b1;
      @(negedge clk_sd);
      checks++;
      if (gptp_ts_vaild !== 1'b1) begin errors++; $display("FAIL late_vaild_rise: got %b want 1", gptp_ts_vaild); end
      n = 0;
      while (gptp_ts_vaild === 1'b1 && n < 20) begin @(negedge clk_sd); n++; end
      gptp_ts_rv_vaild = 1'b1;
      gptp_ts_rv_data  = wb_b;
      @(negedge clk_sd);
      gptp_ts_rv_vaild = 1'b0;
      checks++;
      if (egr_ts_valid !== 1'b1 || egr_ts_data !== wb_b) begin
         errors++; $display("FAIL late_wb_report: got valid=%b ts=%h want 1/%h", egr_ts_valid, egr_ts_data, wb_b);
      end
      checks++;
      if (egr_seq !== 4'd1 || egr_timeout !== 1'b0) begin errors++; $display("FAIL late_seq: got %0d/%b want 1/0", egr_seq, egr_timeout); end
      @(negedge clk_sd);
      checks++;
      if (egr_ts_valid !== 1'b0) begin errors++; $display("FAIL late_one_cycle: got %b want 0", egr_ts_valid); end
   endtask

   task automatic test_timeout();
      int rep_at;
      logic [SW-1:0] s;
      logic tm;
      logic [TSW-1:0] d;
      timed_offer(-1, '0, rep_at, s, tm, d);
      checks++;
      if (rep_at != 1024) begin errors++; $display("FAIL timeout_latency: got %0d want 1024", rep_at); end
      checks++;
      if (tm !== 1'b1 || d !== '0) begin errors++; $display("FAIL timeout_flag: got tmo=%b ts=%h want 1/0", tm, d); end
      checks++;
      if (s !== 4'd2) begin errors++; $display("FAIL timeout_seq: got %0d want 2", s); end
   endtask

   task automatic test_race();
      int rep_at;
      logic [SW-1:0] s;
      logic tm;
      logic [TSW-1:0] d;
      timed_offer(1023, wb_c, rep_at, s, tm, d);
      checks++;
      if (rep_at != 1024) begin errors++; $display("FAIL race_latency: got %0d want 1024", rep_at); end
      checks++;
      if (tm !== 1'b0 || d !== wb_c) begin errors++; $display("FAIL race_ts_wins: got tmo=%b ts=%h want 0/%h", tm, d, wb_c); end
      checks++;
      if (s !== 4'd3) begin errors++; $display("FAIL race_seq: got %0d want 3", s); end
   endtask

   task automatic test_seq_wrap();
      logic [SW-1:0] s;
      bit tm, ok, all_ok;
      logic [TSW-1:0] d;
      all_ok = 1;
      for (int k = 0; k < 14; k++) begin
         run_msg(1'b1, wb_a, s, tm, d, ok);
         if (!ok) all_ok = 0;
         if (k == 11) begin
            checks++;
            if (s !== 4'd15) begin errors++; $display("FAIL wrap_max: got %0d want 15", s); end
         end
         if (k == 12) begin
            checks++;
            if (s !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", s); end
         end
         if (k == 13) begin
            checks++;
            if (s !== 4'd1 || d !== wb_a) begin errors++; $display("FAIL wrap_next: got %0d ts=%h want 1/%h", s, d, wb_a); end
         end
      end
      checks++;
      if (!all_ok) begin errors++; $display("FAIL wrap_reports: got missing report want 14 reports"); end
   endtask

   task automatic test_reset_mid_hold();
      int n;
      bit stray_rep, stray_v, ok;
      logic [SW-1:0] s;
      bit tm;
      logic [TSW-1:0] d;
      stray_rep = 0; stray_v = 0;
      gptp_ts_ready = 1'b1;
      msg_data  = pat_a;
      msg_valid = 1'b1;
      n = 0;
      while (msg_ready !== 1'b1 && n < 50) begin @(negedge clk_sd); n++; end
      @(negedge clk_sd);
      msg_valid = 1'b0;
      n = 0;
      while (gptp_ts_vaild !== 1'b1 && n < 50) begin @(negedge clk_sd); n++; end
      repeat (2) @(negedge clk_sd);
      reset = 1'b0;
      @(negedge clk_sd);
      checks++;
      if (gptp_ts_vaild !== 1'b0 || busy !== 1'b0 || msg_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_flags: got vaild=%b busy=%b rdy=%b want 0/0/0", gptp_ts_vaild, busy, msg_ready);
      end
      checks++;
      if (egr_seq !== 4'd0 || egr_ts_data !== '0 || gptp_ts_data !== '0) begin
         errors++; $display("FAIL midreset_regs: got seq=%0d ts=%h want 0/0", egr_seq, egr_ts_data);
      end
      reset = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk_sd);
         if (egr_ts_valid !== 1'b0) stray_rep = 1;
         if (gptp_ts_vaild !== 1'b0) stray_v = 1;
      end
      checks++;
      if (stray_rep || stray_v) begin errors++; $display("FAIL midreset_quiet: got report/vaild want none"); end
      run_msg(1'b1, wb_b, s, tm, d, ok);
      checks++;
      if (!ok || s !== 4'd0 || d !== wb_b) begin errors++; $display("FAIL midreset_restart: got ok=%b seq=%0d want 1/0", ok, s); end
   endtask

`ifdef GPTP_SD_SENDER_STATS_EN
   task automatic test_stats();
      logic [SW-1:0] s;
      bit tm, ok;
      logic [TSW-1:0] d;
      reset = 1'b0;
      repeat (2) @(negedge clk_sd);
      reset = 1'b1;
      checks++;
      if (stat_sent !== 16'd0 || stat_timeout !== 16'd0 || stat_stray !== 16'd0) begin
         errors++; $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", stat_sent, stat_timeout, stat_stray);
      end
      gptp_ts_rv_vaild = 1'b1;
      @(negedge clk_sd);
      gptp_ts_rv_vaild = 1'b0;
      @(negedge clk_sd);
      for (int k = 0; k < 3; k++) run_msg(1'b1, wb_a, s, tm, d, ok);
      run_msg(1'b0, '0, s, tm, d, ok);
      @(negedge clk_sd);
      checks++;
      if (stat_stray !== 16'd1) begin errors++; $display("FAIL stats_stray: got %0d want 1", stat_stray); end
      checks++;
      if (stat_sent !== 16'd4) begin errors++; $display("FAIL stats_sent: got %0d want 4", stat_sent); end
      checks++;
      if (stat_timeout !== 16'd1) begin errors++; $display("FAIL stats_timeout: got %0d want 1", stat_timeout); end
   endtask
`endif

   initial begin
      pat_a = {44{8'hA5}};
      pat_b = {11{32'hDEAD_BEEF}};
      wb_a  = 80'h0001_0000_0010_0000_0100;
      wb_b  = ts_pack(16'h0002, 32'h0000_0003, 32'h0000_0004);
      wb_c  = 80'h00AB_1234_5678_0BAD_F00D;
      test_reset();
      test_normal();
      test_ready_late();
      test_timeout();
      test_race();
      test_seq_wrap();
      test_reset_mid_hold();
`ifdef GPTP_SD_SENDER_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
